// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with optional
// same-cycle write bypass, one synchronous write port, a debug read port and a saturating write counter.
module reg_file #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int NUM_REGS   = 8,
    parameter int BYPASS     = 1,
    parameter int RESET_INIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] DbgSel,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DbgData,
    output logic [7:0]        WriteCount
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [7:0]        wcount_q;
    logic [7:0]        wcount_d;
    logic              wr_en;

    // Addresses at or beyond NUM_REGS match no entry and therefore read as zero.
    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) val = regs_q[i];
        end
        return val;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign wr_en = RegWrite && in_range(WriteReg);

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        wcount_d = wcount_q;
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = (RESET_INIT != 0) ? DATA_W'(i) : '0;
            end
            wcount_d = '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (WriteReg == ADDR_W'(i)) regs_d[i] = WriteData;
            end
            if (wcount_q != 8'hFF) wcount_d = wcount_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
        wcount_q <= wcount_d;
    end

    // Bypass is suppressed while reset is high because the pending write is discarded.
    always_comb begin
        ReadData1 = stored(ReadReg1);
        ReadData2 = stored(ReadReg2);
        if ((BYPASS != 0) && wr_en && !reset) begin
            if (ReadReg1 == WriteReg) ReadData1 = WriteData;
            if (ReadReg2 == WriteReg) ReadData2 = WriteData;
        end
    end

    assign DbgData    = stored(DbgSel);
    assign WriteCount = wcount_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: three configurations driven from shared inputs,
// expected values queued by the stimulus and checked by a separate negedge monitor.
module tb_reg_file;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ReadReg1, ReadReg2, WriteReg, DbgSel;
    logic [7:0] WriteData;
    logic       RegWrite;

    logic [7:0] a_rd1, a_rd2, a_dbg, a_wc;
    logic [7:0] b_rd1, b_rd2, b_dbg, b_wc;
    logic [7:0] c_rd1, c_rd2, c_dbg, c_wc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: bypass, zero reset image, 8 registers
    reg_file #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .BYPASS(1), .RESET_INIT(0)) u_a (
        .clk(clk), .reset(reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite), .DbgSel(DbgSel),
        .ReadData1(a_rd1), .ReadData2(a_rd2), .DbgData(a_dbg), .WriteCount(a_wc));

    // B: no bypass, reset image r[i] = i, 8 registers
    reg_file #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .BYPASS(0), .RESET_INIT(1)) u_b (
        .clk(clk), .reset(reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite), .DbgSel(DbgSel),
        .ReadData1(b_rd1), .ReadData2(b_rd2), .DbgData(b_dbg), .WriteCount(b_wc));

    // C: bypass, zero reset image, only 6 registers
    reg_file #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(6), .BYPASS(1), .RESET_INIT(0)) u_c (
        .clk(clk), .reset(reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite), .DbgSel(DbgSel),
        .ReadData1(c_rd1), .ReadData2(c_rd2), .DbgData(c_dbg), .WriteCount(c_wc));

    typedef struct {
        int         id;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    function automatic logic [7:0] observe(input int id);
        case (id)
            0: return a_rd1;   1: return a_rd2;   2: return a_dbg;   3: return a_wc;
            4: return b_rd1;   5: return b_rd2;   6: return b_dbg;   7: return b_wc;
            8: return c_rd1;   9: return c_rd2;  10: return c_dbg;  11: return c_wc;
            default: return 8'hxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb.pop_front();
            act = observe(e.id);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic push(input int id, input logic [7:0] v, input string nm);
        exp_t e;
        e.id = id; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    // base: 0 = A, 4 = B, 8 = C
    task automatic push_rd(input int base, input logic [7:0] r1, input logic [7:0] r2,
                           input logic [7:0] dbg, input string tag);
        push(base + 0, r1,  {tag, ".rd1"});
        push(base + 1, r2,  {tag, ".rd2"});
        push(base + 2, dbg, {tag, ".dbg"});
    endtask

    task automatic push_wc(input logic [7:0] wa, input logic [7:0] wb, input logic [7:0] wc,
                           input string tag);
        push(3,  wa, {tag, ".A.wc"});
        push(7,  wb, {tag, ".B.wc"});
        push(11, wc, {tag, ".C.wc"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [2:0] wa,
                         input logic [7:0] wd, input logic [2:0] r1, input logic [2:0] r2,
                         input logic [2:0] ds);
        reset = rst; RegWrite = we; WriteReg = wa; WriteData = wd;
        ReadReg1 = r1; ReadReg2 = r2; DbgSel = ds;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] a3, b3;
        drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0);
        tick();

        // Reset image sweep
        for (int i = 0; i < 8; i++) begin
            a3 = 3'(i);
            b3 = 3'(7 - i);
            drive(1'b0, 1'b0, 3'd0, 8'h00, a3, b3, a3);
            push_rd(0, 8'h00, 8'h00, 8'h00, $sformatf("rst_sweep%0d.A", i));
            push_rd(4, 8'(i), 8'(7 - i), 8'(i), $sformatf("rst_sweep%0d.B", i));
            push_rd(8, 8'h00, 8'h00, 8'h00, $sformatf("rst_sweep%0d.C", i));
            if (i == 0) push_wc(8'd0, 8'd0, 8'd0, "rst");
            tick();
        end

        // Write 0x5A to r3, then read it back on every port
        drive(1'b0, 1'b1, 3'd3, 8'h5A, 3'd0, 3'd1, 3'd3);
        push(2, 8'h00, "w3.A.dbg_old");
        push(6, 8'h03, "w3.B.dbg_old");
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 3'd3);
        push_rd(0, 8'h5A, 8'h5A, 8'h5A, "r3.A");
        push_rd(4, 8'h5A, 8'h5A, 8'h5A, "r3.B");
        push_rd(8, 8'h5A, 8'h5A, 8'h5A, "r3.C");
        push_wc(8'd1, 8'd1, 8'd1, "w3");
        tick();

        // Write 0xC3 to r5: bypass on A/C, stored value on B, debug never bypassed
        drive(1'b0, 1'b1, 3'd5, 8'hC3, 3'd5, 3'd5, 3'd5);
        push_rd(0, 8'hC3, 8'hC3, 8'h00, "byp5.A");
        push_rd(4, 8'h05, 8'h05, 8'h05, "byp5.B");
        push_rd(8, 8'hC3, 8'hC3, 8'h00, "byp5.C");
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 3'd5);
        push_rd(0, 8'hC3, 8'hC3, 8'hC3, "r5.A");
        push_rd(4, 8'hC3, 8'hC3, 8'hC3, "r5.B");
        push_wc(8'd2, 8'd2, 8'd2, "w5");
        tick();

        // ALU loop: r1=0x10, r2=0x25, r4 <= r1+r2
        drive(1'b0, 1'b1, 3'd1, 8'h10, 3'd0, 3'd0, 3'd0); tick();
        drive(1'b0, 1'b1, 3'd2, 8'h25, 3'd0, 3'd0, 3'd0); tick();
        drive(1'b0, 1'b1, 3'd4, 8'h10 + 8'h25, 3'd1, 3'd2, 3'd4);
        push_rd(0, 8'h10, 8'h25, 8'h00, "alu1.A");
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 3'd4);
        push_rd(0, 8'h35, 8'h35, 8'h35, "alu1_r4.A");
        push_rd(8, 8'h35, 8'h35, 8'h35, "alu1_r4.C");
        tick();

        // Wrapping sum: 0xF0 + 0x20 = 0x10
        drive(1'b0, 1'b1, 3'd1, 8'hF0, 3'd0, 3'd0, 3'd0); tick();
        drive(1'b0, 1'b1, 3'd2, 8'h20, 3'd0, 3'd0, 3'd0); tick();
        drive(1'b0, 1'b1, 3'd4, 8'h10, 3'd1, 3'd2, 3'd4);
        push_rd(4, 8'hF0, 8'h20, 8'h35, "alu2.B");
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd1, 3'd2);
        push_rd(0, 8'h10, 8'hF0, 8'h20, "alu2_r4.A");
        push_rd(4, 8'h10, 8'hF0, 8'h20, "alu2_r4.B");
        push_wc(8'd8, 8'd8, 8'd8, "alu");
        tick();

        // Back-to-back writes to r7: last wins; out of range on C (ignored, reads 0, no bypass)
        drive(1'b0, 1'b1, 3'd7, 8'h11, 3'd7, 3'd0, 3'd7);
        push(0, 8'h11, "w7a.A.rd1_byp");
        push(8, 8'h00, "w7a.C.rd1_oor");
        tick();
        drive(1'b0, 1'b1, 3'd7, 8'h22, 3'd0, 3'd0, 3'd7);
        push(2, 8'h11, "w7b.A.dbg");
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd7, 3'd7);
        push_rd(0, 8'h22, 8'h22, 8'h22, "r7.A");
        push_rd(4, 8'h22, 8'h22, 8'h22, "r7.B");
        push_rd(8, 8'h00, 8'h00, 8'h00, "r7.C");
        push_wc(8'd10, 8'd10, 8'd8, "w7");
        tick();

        // Reset together with a write to r6: write discarded, no bypass during reset
        drive(1'b1, 1'b1, 3'd6, 8'hFF, 3'd6, 3'd3, 3'd6);
        push(0, 8'h00, "rstw.A.rd1_nobyp");
        push(4, 8'h06, "rstw.B.rd1_nobyp");
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd3, 3'd6);
        push_rd(0, 8'h00, 8'h00, 8'h00, "rstw_after.A");
        push_rd(4, 8'h06, 8'h03, 8'h06, "rstw_after.B");
        push_rd(8, 8'h00, 8'h00, 8'h00, "rstw_after.C");
        push_wc(8'd0, 8'd0, 8'd0, "rstw");
        tick();

        // 300 writes to r0: counter saturates at 255
        for (int k = 0; k < 300; k++) begin
            drive(1'b0, 1'b1, 3'd0, 8'(k), 3'd1, 3'd1, 3'd0);
            if (k == 254) push_wc(8'd254, 8'd254, 8'd254, "sat254");
            if (k == 255) push_wc(8'd255, 8'd255, 8'd255, "sat255");
            tick();
        end
        drive(1'b0, 1'b1, 3'd7, 8'h77, 3'd0, 3'd0, 3'd0);
        push_rd(0, 8'h2B, 8'h2B, 8'h2B, "sat_r0.A");
        push_rd(8, 8'h2B, 8'h2B, 8'h2B, "sat_r0.C");
        push_wc(8'd255, 8'd255, 8'd255, "sat_end");
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd0, 3'd7);
        push_wc(8'd255, 8'd255, 8'd255, "sat_hold");
        push(0, 8'h77, "sat_r7.A");
        tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file directly upstream of the ALU. Two combinational read ports: ReadData1 feeds the operand mux that produces Mux1Output; ReadData2 feeds the ALU directly.
- One synchronous write port takes the ALU result (ALUOutput) back as WriteData, closing the single-cycle datapath loop.
- Optional same-cycle write-to-read bypass, plus a debug read port for bench and board inspection.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of implemented registers; must be ≤ 2**ADDR_W.
- BYPASS, 1, 1 = read ports forward WriteData when reading the register being written this cycle; 0 = read ports show the stored value only.
- RESET_INIT, 0, 0 = reset clears every register to 0; 1 = reset loads register i with value i (truncated to DATA_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ReadReg1  input  ADDR_W  read port 1 address.
- ReadReg2  input  ADDR_W  read port 2 address.
- WriteReg  input  ADDR_W  write port address.
- WriteData  input  DATA_W  write data, driven by ALUOutput.
- RegWrite  input  1  write enable from control.
- DbgSel  input  ADDR_W  debug read address.
- ReadData1  output  DATA_W  register[ReadReg1], combinational.
- ReadData2  output  DATA_W  register[ReadReg2], combinational.
- DbgData  output  DATA_W  register[DbgSel], combinational, never bypassed.
- WriteCount  output  8  saturating count of committed writes.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high, port name reset. All storage is in flops updated on the rising edge of clk.
- Reset: on a clk edge with reset=1:
  - every register is set per RESET_INIT;
  - WriteCount is set to 0;
  - any concurrent write is discarded, because reset has priority over RegWrite.
- Read outputs after reset: the reset image of each addressed register (all 0 when RESET_INIT=0). These appear combinationally from the cycle after the reset edge.
- Write:
  - On a rising edge with reset=0, RegWrite=1 and WriteReg < NUM_REGS: register[WriteReg] ← WriteData and WriteCount increments.
  - Latency is 1 cycle: the stored value is visible on the non-bypassed read ports from the cycle after the edge.
- Write ignored: RegWrite=0, or WriteReg ≥ NUM_REGS. No state change and no WriteCount increment.
- Read:
  - Purely combinational, zero latency.
  - An address ≥ NUM_REGS returns 0 on ReadData1, ReadData2 and DbgData.
- Bypass (BYPASS=1): if RegWrite=1, reset=0, WriteReg < NUM_REGS and ReadRegN == WriteReg, then ReadDataN = WriteData in that same cycle. Each port evaluates this independently, so both ports may bypass at once.
- Bypass off: with BYPASS=0, or with reset=1, ReadDataN always shows the stored value.
- DbgData always shows the stored value.
- Width rules:
  - WriteData is stored unmodified; there is no sign handling in this block.
  - WriteCount saturates at 255; further writes leave it at 255.
- Reset mid-operation: reset asserted together with RegWrite leaves the target register at its reset value on the next cycle, not WriteData.
- Back-to-back writes to the same register: the last write wins. Each write increments WriteCount.
- Outputs depend only on current inputs and flop state. There are no latches, and no X propagation out of unused addresses.

Test Plan:
- Reset with RESET_INIT=0, then sweep ReadReg1/ReadReg2/DbgSel over 0..7 -> all read 0x00; WriteCount=0.
- Write 0x5A to r3 (RegWrite=1, WriteReg=3); next cycle ReadReg1=3, ReadReg2=3 -> both 0x5A; DbgSel=3 -> 0x5A; WriteCount=1.
- BYPASS=1: in the write cycle of 0xC3 to r5, ReadReg2=5 -> ReadData2=0xC3 in the same cycle and DbgData (DbgSel=5) = old value 0x00. Repeat with BYPASS=0 -> ReadData2=0x00 until the next cycle.
- ALU loop: r1=0x10, r2=0x25, ALU sum 0x35 written to r4 -> r4=0x35. r1=0xF0, r2=0x20 -> wrapped sum 0x10 stored in r4.
- Reset and RegWrite together (WriteReg=6, WriteData=0xFF), RESET_INIT=1 -> r6 reads 0x06 next cycle; WriteCount=0.
- NUM_REGS=6: write to r7 ignored (WriteCount unchanged), ReadReg1=7 -> 0x00. 300 valid writes -> WriteCount saturates at 255.
